// File: rtl/mips_defines.sv
// rtl/mips_defines.sv - shared MIPS pipeline constants and divider state encodings
package mips_defines;

  localparam logic        RSTENABLE  = 1'b1;
  localparam logic        RSTDISABLE = 1'b0;
  localparam logic [31:0] ZEROWORD   = 32'h0000_0000;

  // EX-side aluop codes; EX maps these onto signed_div_i
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP  = 1'b0;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_t;

endpackage

// File: rtl/div.sv
// rtl/div.sv - multi-cycle radix-2 restoring divider for MIPS DIV/DIVU
module div
  import mips_defines::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int              CNT_W     = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  div_state_t         state_q, state_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic [WIDTH-1:0]   quo_q, quo_nxt;
  logic [WIDTH-1:0]   rem_q, rem_nxt;
  logic [WIDTH-1:0]   dvs_q, dvs_nxt;
  logic               neg_quo_q, neg_quo_nxt;
  logic               neg_rem_q, neg_rem_nxt;
  logic [2*WIDTH-1:0] result_nxt;
  logic               ready_nxt;

  logic [WIDTH:0]     partial;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   rem_step;
  logic [WIDTH-1:0]   quo_step;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  // quo_q starts as the dividend magnitude and fills with quotient bits from the LSB
  assign partial  = {rem_q, quo_q[WIDTH-1]};
  assign diff     = partial - {1'b0, dvs_q};
  assign rem_step = diff[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : diff[WIDTH-1:0];
  assign quo_step = {quo_q[WIDTH-2:0], ~diff[WIDTH]};

  always_ff @(posedge clk) begin
    if (rst == RSTENABLE) begin
      state_q   <= DIV_FREE;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_o  <= '0;
      ready_o   <= DIV_RESULT_NOT_READY;
    end else begin
      state_q   <= state_nxt;
      cnt_q     <= cnt_nxt;
      quo_q     <= quo_nxt;
      rem_q     <= rem_nxt;
      dvs_q     <= dvs_nxt;
      neg_quo_q <= neg_quo_nxt;
      neg_rem_q <= neg_rem_nxt;
      result_o  <= result_nxt;
      ready_o   <= ready_nxt;
    end
  end

  always_comb begin
    state_nxt   = state_q;
    cnt_nxt     = cnt_q;
    quo_nxt     = quo_q;
    rem_nxt     = rem_q;
    dvs_nxt     = dvs_q;
    neg_quo_nxt = neg_quo_q;
    neg_rem_nxt = neg_rem_q;
    result_nxt  = result_o;
    ready_nxt   = ready_o;

    case (state_q)
      DIV_FREE: begin
        result_nxt = '0;
        ready_nxt  = DIV_RESULT_NOT_READY;
        if (start_i == DIV_START && annul_i == 1'b0) begin
          if (opdata2_i == '0) begin
            state_nxt = DIV_BY_ZERO;
          end else begin
            state_nxt   = DIV_ON;
            cnt_nxt     = '0;
            quo_nxt     = cond_neg(opdata1_i, signed_div_i & opdata1_i[WIDTH-1]);
            dvs_nxt     = cond_neg(opdata2_i, signed_div_i & opdata2_i[WIDTH-1]);
            rem_nxt     = '0;
            neg_quo_nxt = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_rem_nxt = signed_div_i & opdata1_i[WIDTH-1];
          end
        end
      end

      DIV_BY_ZERO: begin
        state_nxt  = DIV_END;
        result_nxt = '0;
        ready_nxt  = DIV_RESULT_READY;
      end

      DIV_ON: begin
        if (annul_i) begin
          state_nxt  = DIV_FREE;
          result_nxt = '0;
          ready_nxt  = DIV_RESULT_NOT_READY;
        end else begin
          quo_nxt = quo_step;
          rem_nxt = rem_step;
          cnt_nxt = cnt_q + CNT_W'(1);
          // last iteration lands directly in END with the sign fix-up applied
          if (cnt_q == LAST_ITER) begin
            state_nxt  = DIV_END;
            result_nxt = {cond_neg(rem_step, neg_rem_q), cond_neg(quo_step, neg_quo_q)};
            ready_nxt  = DIV_RESULT_READY;
          end
        end
      end

      DIV_END: begin
        if (start_i == DIV_STOP || annul_i) begin
          state_nxt  = DIV_FREE;
          result_nxt = '0;
          ready_nxt  = DIV_RESULT_NOT_READY;
        end
      end

      default: begin
        state_nxt  = DIV_FREE;
        result_nxt = '0;
        ready_nxt  = DIV_RESULT_NOT_READY;
      end
    endcase
  end

endmodule

// File: tb/tb_div.sv
// tb/tb_div.sv - scoreboard bench for div: random DIV/DIVU ops against an arithmetic model
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  div #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    int unsigned rise;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // C-style truncating division on 64-bit values; {remainder, quotient}, 0 for divide by zero
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sbv, q, r;
    if (b == 32'd0) return 64'd0;
    sa  = sgn ? longint'(signed'(a)) : longint'({32'd0, a});
    sbv = sgn ? longint'(signed'(b)) : longint'({32'd0, b});
    q = sa / sbv;
    r = sa % sbv;
    return {r[31:0], q[31:0]};
  endfunction

  // Monitor: every rising ready_o must match the oldest outstanding op, on the predicted cycle
  logic prev_ready = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (ready_o === 1'b1 && prev_ready === 1'b0) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ready: ready_o rose at cycle %0d with result %h, none outstanding", cyc, result_o);
      end else begin
        e = sb.pop_front();
        check64("result", result_o, e.res);
        check_int("ready_cycle", cyc, e.rise);
      end
    end
    prev_ready = ready_o;
  end

  // Drive start on the current negedge; the FSM samples it at edge S = cyc+1.
  // Latency counts rising edges from S to the first edge that sees ready_o high.
  task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b, input bit keep);
    exp_t e;
    int unsigned lat;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    if (keep) begin
      lat    = (b == 32'd0) ? 2 : 33;
      e.res  = ref_div(sgn, a, b);
      e.rise = cyc + 1 + lat - 1;
      sb.push_back(e);
    end
  endtask

  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit now);
    int n;
    logic [63:0] exp;
    exp = ref_div(sgn, a, b);
    if (!now) @(negedge clk);
    issue(sgn, a, b, 1'b1);
    n = 0;
    while (ready_o !== 1'b1 && n < 100) begin
      @(negedge clk);
      opdata1_i    = $urandom;
      opdata2_i    = $urandom;
      signed_div_i = 1'($urandom);
      n++;
    end
    if (ready_o !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: ready_o still %b after %0d cycles", ready_o, n);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_int("held_ready", 32'(ready_o), 1);
      check64("held_result", result_o, exp);
    end
    start_i = 1'b0;
    @(negedge clk);
    check_int("drop_ready", 32'(ready_o), 0);
    check64("drop_result", result_o, 64'd0);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  function automatic logic [31:0] pick_operand(input int cls);
    case (cls)
      0:       return 32'd0;
      1:       return 32'($urandom_range(1, 15));
      2:       return -32'($urandom_range(1, 15));
      3:       return ($urandom_range(0, 1) == 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int seen;
    logic [31:0] a, b;
    rst          = 1'b1;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    repeat (3) @(negedge clk);
    check_int("reset_ready", 32'(ready_o), 0);
    check64("reset_result", result_o, 64'd0);
    rst = 1'b0;

    run_op(1'b0, 32'd100, 32'd7, 2, 1'b0);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1, 1'b0);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1'b0);
    run_op(1'b0, 32'd5, 32'd0, 3, 1'b0);

    // cancel ten cycles into the iteration; no result may ever appear
    @(negedge clk);
    issue(1'b0, 32'd1000, 32'd7, 1'b0);
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o !== 1'b0) seen++;
    end
    check_int("annul_no_ready", seen, 0);
    run_op(1'b0, 32'd9, 32'd3, 1, 1'b0);

    // reset twenty cycles into the iteration, then start right after release
    @(negedge clk);
    issue(1'b1, 32'hDEAD_BEEF, 32'd5, 1'b0);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    check_int("midop_reset_ready", 32'(ready_o), 0);
    check64("midop_reset_result", result_o, 64'd0);
    rst = 1'b0;
    run_op(1'b1, 32'hFFFF_FF9C, 32'd9, 0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      a = pick_operand($urandom_range(1, 6));
      b = pick_operand($urandom_range(0, 6));
      run_op(1'($urandom), a, b, $urandom_range(0, 3), 1'b0);
    end

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL pending_ops: got %0d outstanding expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
